// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter sequencer: counter control codes and FSM states.
package counter_sequencer_pkg;

  localparam logic [1:0] CTRL_CLEAR = 2'd0;
  localparam logic [1:0] CTRL_UP    = 2'd1;
  localparam logic [1:0] CTRL_DOWN  = 2'd2;
  localparam logic [1:0] CTRL_LOAD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STEP   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/counter4bit.sv
// Loadable up/down counter driven by a 2-bit control code (clear/up/down/load).
module counter4bit
  import counter_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   i_control,
  input  logic [W-1:0] i_load,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case (i_control)
        CTRL_CLEAR: r_count <= '0;
        CTRL_UP:    r_count <= r_count + W'(1);
        CTRL_DOWN:  r_count <= r_count - W'(1);
        default:    r_count <= i_load;
      endcase
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_sequencer.sv
// Drives a loadable counter from a start value to a target, checking its count against a shadow copy.
// Holding is always done as a load of the held value, since the counter has no hold code.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [W-1:0] i_start_val,
  input  logic [W-1:0] i_target_val,
  input  logic [W-1:0] i_count_in,
  output logic [1:0]   o_control,
  output logic [W-1:0] o_load,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [W-1:0] o_steps
);

  state_t       r_state;
  logic [1:0]   r_control;
  logic [1:0]   r_dir;
  logic [W-1:0] r_load;
  logic [W-1:0] r_shadow;
  logic [W-1:0] r_target;
  logic [W-1:0] r_steps;
  logic         r_busy;
  logic         r_done;
  logic         r_error;

  logic [W-1:0] w_next_shadow;
  logic         w_mismatch;

  assign w_next_shadow = (r_dir == CTRL_UP) ? r_shadow + W'(1) : r_shadow - W'(1);
  assign w_mismatch    = (i_count_in != r_shadow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_control <= CTRL_LOAD;
      r_load    <= '0;
      r_dir     <= CTRL_UP;
      r_shadow  <= '0;
      r_target  <= '0;
      r_steps   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort and mismatch both freeze the counter at whatever it currently shows.
      if (r_state != IDLE && (i_stop || (r_state != LOAD && w_mismatch))) begin
        r_control <= CTRL_LOAD;
        r_load    <= i_count_in;
        r_busy    <= 1'b0;
        r_state   <= IDLE;
        if (!i_stop) r_error <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !i_stop) begin
              r_target  <= i_target_val;
              r_shadow  <= i_start_val;
              r_dir     <= (i_target_val > i_start_val) ? CTRL_UP : CTRL_DOWN;
              r_error   <= 1'b0;
              r_steps   <= '0;
              r_control <= CTRL_LOAD;
              r_load    <= i_start_val;
              r_busy    <= 1'b1;
              r_state   <= LOAD;
            end
          end
          LOAD: begin
            if (r_shadow == r_target) begin
              r_control <= CTRL_LOAD;
              r_load    <= r_target;
              r_state   <= FINISH;
            end else begin
              r_control <= r_dir;
              r_state   <= STEP;
            end
          end
          STEP: begin
            r_shadow <= w_next_shadow;
            r_steps  <= r_steps + W'(1);
            if (w_next_shadow == r_target) begin
              r_control <= CTRL_LOAD;
              r_load    <= r_target;
              r_state   <= FINISH;
            end
          end
          FINISH: begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_control = r_control;
  assign o_load    = r_load;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_steps   = r_steps;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: counter_sequencer driving a counter4bit, with an optional stuck-count override.
module tb_counter_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] start_val;
  logic [W-1:0] target_val;
  logic [1:0]   control;
  logic [W-1:0] load;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] steps;
  logic [W-1:0] cnt_count;
  logic [W-1:0] count_in;
  logic         force_en;
  logic [W-1:0] force_val;

  int n_chk;
  int n_pass;
  int n_down;

  assign count_in = force_en ? force_val : cnt_count;

  counter_sequencer #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_stop       (stop),
    .i_start_val  (start_val),
    .i_target_val (target_val),
    .i_count_in   (count_in),
    .o_control    (control),
    .o_load       (load),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_steps      (steps)
  );

  counter4bit #(.W(W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_control (control),
    .i_load    (load),
    .o_count   (cnt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [W-1:0] sv, input logic [W-1:0] tv);
    start_val  = sv;
    target_val = tv;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_down = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    start_val = '0; target_val = '0; force_en = 1'b0; force_val = '0;
    #1;
    chk("rst_control", 32'(control), 3);
    chk("rst_load",    32'(load), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_error",   32'(error), 0);
    chk("rst_steps",   32'(steps), 0);
    chk("rst_count",   32'(cnt_count), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Run 3 -> 7: edge0 start sampled
    kick(4'd3, 4'd7);
    chk("a_e0_control", 32'(control), 3);
    chk("a_e0_load",    32'(load), 3);
    chk("a_e0_busy",    32'(busy), 1);
    tick();
    chk("a_e1_control", 32'(control), 1);
    chk("a_e1_count",   32'(cnt_count), 3);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("a_step_control", 32'(control), 1);
      chk("a_step_count",   32'(cnt_count), 32'(k + 2));
    end
    tick();
    chk("a_e5_control", 32'(control), 3);
    chk("a_e5_load",    32'(load), 7);
    chk("a_e5_count",   32'(cnt_count), 7);
    chk("a_e5_done",    32'(done), 0);
    tick();
    chk("a_e6_done",  32'(done), 1);
    chk("a_e6_busy",  32'(busy), 0);
    chk("a_e6_steps", 32'(steps), 4);
    chk("a_e6_error", 32'(error), 0);
    tick();
    chk("a_e7_done",  32'(done), 0);
    chk("a_e7_count", 32'(cnt_count), 7);

    // Run 12 -> 2: ten DOWN codes
    kick(4'd12, 4'd2);
    tick();
    if (control == 2'd2) n_down++;
    chk("b_e1_count", 32'(cnt_count), 12);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (control == 2'd2) n_down++;
      chk("b_step_count", 32'(cnt_count), 32'(13 - k));
    end
    tick();
    chk("b_down_codes", 32'(n_down), 10);
    chk("b_e11_control", 32'(control), 3);
    chk("b_e11_load",    32'(load), 2);
    chk("b_e11_count",   32'(cnt_count), 2);
    chk("b_e11_done",    32'(done), 0);
    tick();
    chk("b_e12_done",  32'(done), 1);
    chk("b_e12_steps", 32'(steps), 10);
    chk("b_e12_busy",  32'(busy), 0);
    tick();

    // Run 5 -> 5: load, hold, done after edge 2
    kick(4'd5, 4'd5);
    tick();
    chk("c_e1_control", 32'(control), 3);
    chk("c_e1_load",    32'(load), 5);
    chk("c_e1_count",   32'(cnt_count), 5);
    chk("c_e1_done",    32'(done), 0);
    tick();
    chk("c_e2_done",  32'(done), 1);
    chk("c_e2_steps", 32'(steps), 0);
    chk("c_e2_count", 32'(cnt_count), 5);
    tick();

    // Run 3 -> 7 with count_in stuck at 4
    force_val = 4'd4;
    force_en  = 1'b1;
    kick(4'd3, 4'd7);
    tick();
    chk("d_e1_error", 32'(error), 0);
    chk("d_e1_busy",  32'(busy), 1);
    tick();
    chk("d_e2_error",   32'(error), 1);
    chk("d_e2_busy",    32'(busy), 0);
    chk("d_e2_done",    32'(done), 0);
    chk("d_e2_control", 32'(control), 3);
    chk("d_e2_load",    32'(load), 4);
    tick();
    chk("d_e3_done",    32'(done), 0);
    chk("d_e3_error",   32'(error), 1);
    chk("d_e3_control", 32'(control), 3);
    chk("d_e3_load",    32'(load), 4);
    force_en = 1'b0;
    tick();

    // Run 0 -> 9, stop (with a competing start) in the third STEP cycle
    kick(4'd0, 4'd9);
    chk("e_e0_error_cleared", 32'(error), 0);
    tick(); tick(); tick();
    chk("e_e3_count", 32'(cnt_count), 2);
    stop = 1'b1; start = 1'b1; start_val = 4'd5; target_val = 4'd6;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("e_e4_control", 32'(control), 3);
    chk("e_e4_load",    32'(load), 2);
    chk("e_e4_busy",    32'(busy), 0);
    chk("e_e4_done",    32'(done), 0);
    chk("e_e4_steps",   32'(steps), 2);
    chk("e_e4_error",   32'(error), 0);
    tick();
    chk("e_e5_busy", 32'(busy), 0);
    chk("e_e5_done", 32'(done), 0);
    chk("e_e5_load", 32'(load), 2);
    tick();
    chk("e_e6_count", 32'(cnt_count), 2);

    // Reset mid-STEP, then run 1 -> 3
    kick(4'd2, 4'd9);
    tick(); tick(); tick();
    chk("f_pre_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("f_rst_control", 32'(control), 3);
    chk("f_rst_load",    32'(load), 0);
    chk("f_rst_busy",    32'(busy), 0);
    chk("f_rst_error",   32'(error), 0);
    chk("f_rst_steps",   32'(steps), 0);
    chk("f_rst_count",   32'(cnt_count), 0);
    tick();
    reset = 1'b0;
    tick();
    kick(4'd1, 4'd3);
    tick();
    chk("g_e1_control", 32'(control), 1);
    chk("g_e1_count",   32'(cnt_count), 1);
    tick();
    chk("g_e2_count",   32'(cnt_count), 2);
    tick();
    chk("g_e3_control", 32'(control), 3);
    chk("g_e3_load",    32'(load), 3);
    chk("g_e3_count",   32'(cnt_count), 3);
    tick();
    chk("g_e4_done",  32'(done), 1);
    chk("g_e4_busy",  32'(busy), 0);
    chk("g_e4_steps", 32'(steps), 2);
    chk("g_e4_error", 32'(error), 0);
    tick();
    chk("g_e5_done", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
